// File: rtl/execute_alu.sv
// Registered ARM execute stage: condition check, ALU, address and
// branch-target arithmetic, NZCV flag register.
module execute_alu (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic        stall,
  input  logic        flush,
  input  logic [4:0]  opcode,
  input  logic [3:0]  cond,
  input  logic        set_flags,
  input  logic        up_down,
  input  logic [31:0] rnData,
  input  logic [31:0] shiftedData,
  input  logic [31:0] pcData,
  input  logic [3:0]  rdIn,
  output logic        out_valid,
  output logic [31:0] result,
  output logic [3:0]  rdOut,
  output logic        writeReg,
  output logic        memAccess,
  output logic        branchTaken,
  output logic [3:0]  flags
);

  localparam logic [3:0] OP_AND = 4'h0;
  localparam logic [3:0] OP_EOR = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_RSB = 4'h3;
  localparam logic [3:0] OP_ADD = 4'h4;
  localparam logic [3:0] OP_ADC = 4'h5;
  localparam logic [3:0] OP_SBC = 4'h6;
  localparam logic [3:0] OP_RSC = 4'h7;
  localparam logic [3:0] OP_TST = 4'h8;
  localparam logic [3:0] OP_TEQ = 4'h9;
  localparam logic [3:0] OP_CMP = 4'hA;
  localparam logic [3:0] OP_CMN = 4'hB;
  localparam logic [3:0] OP_ORR = 4'hC;
  localparam logic [3:0] OP_MOV = 4'hD;
  localparam logic [3:0] OP_BIC = 4'hE;
  localparam logic [3:0] OP_MVN = 4'hF;

  logic        valid_q, valid_d;
  logic [31:0] res_q, res_d;
  logic [3:0]  rd_q, rd_d;
  logic        wr_q, wr_d;
  logic        mem_q, mem_d;
  logic        br_q, br_d;
  logic [3:0]  flags_q, flags_d;

  logic        fn, fz, fc, fv;
  logic        pass;
  logic [3:0]  op;
  logic        is_arith;
  logic        is_test;
  logic [31:0] a_op, b_op;
  logic        cin;
  logic [32:0] sum;
  logic [31:0] alu;
  logic        ovf;

  assign fn = flags_q[3];
  assign fz = flags_q[2];
  assign fc = flags_q[1];
  assign fv = flags_q[0];
  assign op = opcode[3:0];

  always_comb begin
    unique case (cond)
      4'h0: pass = fz;
      4'h1: pass = !fz;
      4'h2: pass = fc;
      4'h3: pass = !fc;
      4'h4: pass = fn;
      4'h5: pass = !fn;
      4'h6: pass = fv;
      4'h7: pass = !fv;
      4'h8: pass = fc && !fz;
      4'h9: pass = !fc || fz;
      4'hA: pass = fn == fv;
      4'hB: pass = fn != fv;
      4'hC: pass = !fz && (fn == fv);
      4'hD: pass = fz || (fn != fv);
      4'hE: pass = 1'b1;
      4'hF: pass = 1'b0;
    endcase
  end

  // Subtractions are sums with the subtrahend inverted, so C = NOT borrow.
  always_comb begin
    a_op     = rnData;
    b_op     = shiftedData;
    cin      = 1'b0;
    is_arith = 1'b1;
    if (opcode[4]) begin
      if (opcode[0]) a_op = pcData;
      else if (!up_down) begin
        b_op = ~shiftedData;
        cin  = 1'b1;
      end
    end else begin
      unique case (op)
        OP_SUB, OP_CMP: begin
          b_op = ~shiftedData;
          cin  = 1'b1;
        end
        OP_RSB: begin
          a_op = shiftedData;
          b_op = ~rnData;
          cin  = 1'b1;
        end
        OP_ADD, OP_CMN: cin = 1'b0;
        OP_ADC: cin = fc;
        OP_SBC: begin
          b_op = ~shiftedData;
          cin  = fc;
        end
        OP_RSC: begin
          a_op = shiftedData;
          b_op = ~rnData;
          cin  = fc;
        end
        default: is_arith = 1'b0;
      endcase
    end
  end

  assign sum     = {1'b0, a_op} + {1'b0, b_op} + {32'd0, cin};
  assign ovf     = (a_op[31] == b_op[31]) && (sum[31] != a_op[31]);
  assign is_test = (op[3:2] == 2'b10);

  always_comb begin
    unique case (op)
      OP_AND, OP_TST: alu = rnData & shiftedData;
      OP_EOR, OP_TEQ: alu = rnData ^ shiftedData;
      OP_ORR:         alu = rnData | shiftedData;
      OP_MOV:         alu = shiftedData;
      OP_BIC:         alu = rnData & ~shiftedData;
      OP_MVN:         alu = ~shiftedData;
      default:        alu = sum[31:0];
    endcase
  end

  always_comb begin
    valid_d = valid_q;
    res_d   = res_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    mem_d   = mem_q;
    br_d    = br_q;
    flags_d = flags_q;
    if (flush) begin
      valid_d = 1'b0;
      wr_d    = 1'b0;
      mem_d   = 1'b0;
      br_d    = 1'b0;
    end else if (stall) begin
      valid_d = valid_q;
    end else if (!in_valid) begin
      valid_d = 1'b0;
    end else begin
      valid_d = 1'b1;
      rd_d    = rdIn;
      res_d   = 32'd0;
      wr_d    = 1'b0;
      mem_d   = 1'b0;
      br_d    = 1'b0;
      if (pass) begin
        if (opcode[4]) begin
          res_d = sum[31:0];
          mem_d = !opcode[0];
          br_d  = opcode[0];
        end else begin
          res_d = alu;
          wr_d  = !is_test;
          if (set_flags || is_test) begin
            flags_d[3] = alu[31];
            flags_d[2] = (alu == 32'd0);
            if (is_arith) begin
              flags_d[1] = sum[32];
              flags_d[0] = ovf;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_q <= 1'b0;
      res_q   <= 32'd0;
      rd_q    <= 4'd0;
      wr_q    <= 1'b0;
      mem_q   <= 1'b0;
      br_q    <= 1'b0;
      flags_q <= 4'd0;
    end else begin
      valid_q <= valid_d;
      res_q   <= res_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      mem_q   <= mem_d;
      br_q    <= br_d;
      flags_q <= flags_d;
    end
  end

  assign out_valid   = valid_q;
  assign result      = res_q;
  assign rdOut       = rd_q;
  assign writeReg    = wr_q;
  assign memAccess   = mem_q;
  assign branchTaken = br_q;
  assign flags       = flags_q;

endmodule

// File: tb/tb_execute_alu.sv
// Bench for execute_alu: vector table with a scoreboard queue,
// plus stall/flush/reset sequences.
module tb_execute_alu;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        stall;
  logic        flush;
  logic [4:0]  opcode;
  logic [3:0]  cond;
  logic        set_flags;
  logic        up_down;
  logic [31:0] rnData;
  logic [31:0] shiftedData;
  logic [31:0] pcData;
  logic [3:0]  rdIn;
  logic        out_valid;
  logic [31:0] result;
  logic [3:0]  rdOut;
  logic        writeReg;
  logic        memAccess;
  logic        branchTaken;
  logic [3:0]  flags;

  execute_alu dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .stall(stall),
    .flush(flush), .opcode(opcode), .cond(cond), .set_flags(set_flags),
    .up_down(up_down), .rnData(rnData), .shiftedData(shiftedData),
    .pcData(pcData), .rdIn(rdIn), .out_valid(out_valid),
    .result(result), .rdOut(rdOut), .writeReg(writeReg),
    .memAccess(memAccess), .branchTaken(branchTaken), .flags(flags)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        valid;
    logic [31:0] res;
    logic [3:0]  rd;
    logic        wr;
    logic        mem;
    logic        br;
    logic [3:0]  fl;
  } exp_t;

  typedef struct {
    string       name;
    logic [4:0]  op;
    logic [3:0]  cc;
    logic        s;
    logic        ud;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] pc;
    logic [3:0]  rd;
    exp_t        e;
  } vec_t;

  vec_t vecs[$];
  exp_t sb[$];
  string names[$];
  int passed = 0;
  int total  = 0;

  function automatic exp_t mk(logic v, logic [31:0] r, logic [3:0] d,
                              logic w, logic m, logic b, logic [3:0] f);
    exp_t e;
    e.valid = v; e.res = r; e.rd = d; e.wr = w;
    e.mem = m; e.br = b; e.fl = f;
    return e;
  endfunction

  function automatic vec_t mv(string n, logic [4:0] o, logic [3:0] c,
                              logic s, logic u, logic [31:0] a,
                              logic [31:0] b, logic [31:0] pc,
                              logic [3:0] rd, exp_t e);
    vec_t v;
    v.name = n; v.op = o; v.cc = c; v.s = s; v.ud = u;
    v.a = a; v.b = b; v.pc = pc; v.rd = rd; v.e = e;
    return v;
  endfunction

  task automatic drive(vec_t v);
    opcode = v.op; cond = v.cc; set_flags = v.s; up_down = v.ud;
    rnData = v.a; shiftedData = v.b; pcData = v.pc; rdIn = v.rd;
  endtask

  task automatic check_front();
    exp_t e;
    exp_t g;
    string n;
    e = sb.pop_front();
    n = names.pop_front();
    g = mk(out_valid, result, rdOut, writeReg, memAccess, branchTaken, flags);
    total++;
    if (g === e) passed++;
    else $display("FAIL %s: got v=%0b r=%h rd=%h w=%0b m=%0b b=%0b f=%b want v=%0b r=%h rd=%h w=%0b m=%0b b=%0b f=%b",
                  n, g.valid, g.res, g.rd, g.wr, g.mem, g.br, g.fl,
                  e.valid, e.res, e.rd, e.wr, e.mem, e.br, e.fl);
  endtask

  task automatic step(string n, exp_t e);
    sb.push_back(e);
    names.push_back(n);
    @(posedge clk);
    #1;
    check_front();
  endtask

  initial begin
    vecs.push_back(mv("adds_ovf", 5'h04, 4'hE, 1, 0, 32'h7FFFFFFF, 32'h1, 0, 4'h1,
                      mk(1, 32'h80000000, 4'h1, 1, 0, 0, 4'b1001)));
    vecs.push_back(mv("cmp_eq", 5'h0A, 4'hE, 0, 0, 32'h5, 32'h5, 0, 4'h2,
                      mk(1, 32'h0, 4'h2, 0, 0, 0, 4'b0110)));
    vecs.push_back(mv("moveq", 5'h0D, 4'h0, 0, 0, 0, 32'hAB, 0, 4'h3,
                      mk(1, 32'hAB, 4'h3, 1, 0, 0, 4'b0110)));
    vecs.push_back(mv("movne", 5'h0D, 4'h1, 0, 0, 0, 32'hAB, 0, 4'h4,
                      mk(1, 32'h0, 4'h4, 0, 0, 0, 4'b0110)));
    vecs.push_back(mv("subs_neg", 5'h02, 4'hE, 1, 0, 32'h0, 32'h1, 0, 4'h5,
                      mk(1, 32'hFFFFFFFF, 4'h5, 1, 0, 0, 4'b1000)));
    vecs.push_back(mv("adc_c0", 5'h05, 4'hE, 0, 0, 32'h0, 32'h0, 0, 4'h6,
                      mk(1, 32'h0, 4'h6, 1, 0, 0, 4'b1000)));
    vecs.push_back(mv("ls_up", 5'h10, 4'hE, 1, 1, 32'h100, 32'h10, 0, 4'h7,
                      mk(1, 32'h110, 4'h7, 0, 1, 0, 4'b1000)));
    vecs.push_back(mv("ls_down", 5'h10, 4'hE, 1, 0, 32'h100, 32'h10, 0, 4'h7,
                      mk(1, 32'hF0, 4'h7, 0, 1, 0, 4'b1000)));
    vecs.push_back(mv("b_al", 5'h11, 4'hE, 1, 0, 32'h0, 32'hFFFFFFF8, 32'h208, 4'h8,
                      mk(1, 32'h200, 4'h8, 0, 0, 1, 4'b1000)));
    vecs.push_back(mv("b_nv", 5'h11, 4'hF, 0, 0, 32'h0, 32'hFFFFFFF8, 32'h208, 4'h8,
                      mk(1, 32'h0, 4'h8, 0, 0, 0, 4'b1000)));
    vecs.push_back(mv("cmp_gt", 5'h0A, 4'hE, 0, 0, 32'h5, 32'h3, 0, 4'h9,
                      mk(1, 32'h2, 4'h9, 0, 0, 0, 4'b0010)));
    vecs.push_back(mv("ands_keepc", 5'h00, 4'hE, 1, 0, 32'hF0, 32'h0F, 0, 4'hA,
                      mk(1, 32'h0, 4'hA, 1, 0, 0, 4'b0110)));
    vecs.push_back(mv("rsbs", 5'h03, 4'hE, 1, 0, 32'h1, 32'h0, 0, 4'hB,
                      mk(1, 32'hFFFFFFFF, 4'hB, 1, 0, 0, 4'b1000)));
    vecs.push_back(mv("sbcs_c0", 5'h06, 4'hE, 1, 0, 32'h5, 32'h2, 0, 4'hC,
                      mk(1, 32'h2, 4'hC, 1, 0, 0, 4'b0010)));
    vecs.push_back(mv("mvngt", 5'h0F, 4'hC, 0, 0, 32'h0, 32'h0, 0, 4'hD,
                      mk(1, 32'hFFFFFFFF, 4'hD, 1, 0, 0, 4'b0010)));
    vecs.push_back(mv("movlt", 5'h0D, 4'hB, 0, 0, 32'h0, 32'h7, 0, 4'hE,
                      mk(1, 32'h0, 4'hE, 0, 0, 0, 4'b0010)));
    vecs.push_back(mv("adds_wrap", 5'h04, 4'hE, 1, 0, 32'hFFFFFFFF, 32'h1, 0, 4'h1,
                      mk(1, 32'h0, 4'h1, 1, 0, 0, 4'b0110)));
    vecs.push_back(mv("movhi", 5'h0D, 4'h8, 0, 0, 32'h0, 32'h9, 0, 4'h2,
                      mk(1, 32'h0, 4'h2, 0, 0, 0, 4'b0110)));
    vecs.push_back(mv("orrls", 5'h0C, 4'h9, 0, 0, 32'h1, 32'h2, 0, 4'h3,
                      mk(1, 32'h3, 4'h3, 1, 0, 0, 4'b0110)));
    vecs.push_back(mv("cmn_v", 5'h0B, 4'hE, 0, 0, 32'h80000000, 32'h80000000, 0, 4'h4,
                      mk(1, 32'h0, 4'h4, 0, 0, 0, 4'b0111)));
    vecs.push_back(mv("bicvs", 5'h0E, 4'h6, 0, 0, 32'hFF, 32'h0F, 0, 4'h5,
                      mk(1, 32'hF0, 4'h5, 1, 0, 0, 4'b0111)));
    vecs.push_back(mv("teq", 5'h09, 4'hE, 0, 0, 32'h3, 32'h3, 0, 4'h6,
                      mk(1, 32'h0, 4'h6, 0, 0, 0, 4'b0111)));

    reset = 0; in_valid = 0; stall = 0; flush = 0;
    opcode = 0; cond = 0; set_flags = 0; up_down = 0;
    rnData = 0; shiftedData = 0; pcData = 0; rdIn = 0;
    @(posedge clk);
    step("reset", mk(0, 0, 0, 0, 0, 0, 4'b0000));
    reset = 1;

    in_valid = 1;
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i]);
      step(vecs[i].name, vecs[i].e);
    end

    drive(mv("adds_st", 5'h04, 4'hE, 1, 0, 32'h1, 32'h1, 0, 4'hF,
             mk(0, 0, 0, 0, 0, 0, 0)));
    stall = 1;
    step("stall1", mk(1, 32'h0, 4'h6, 0, 0, 0, 4'b0111));
    step("stall2", mk(1, 32'h0, 4'h6, 0, 0, 0, 4'b0111));
    flush = 1;
    step("flush", mk(0, 32'h0, 4'h6, 0, 0, 0, 4'b0111));
    flush = 0; stall = 0; in_valid = 0;
    step("idle", mk(0, 32'h0, 4'h6, 0, 0, 0, 4'b0111));

    in_valid = 1;
    drive(mv("ls_pre", 5'h10, 4'hE, 0, 1, 32'h40, 32'h4, 0, 4'h9,
             mk(0, 0, 0, 0, 0, 0, 0)));
    step("ls_pre", mk(1, 32'h44, 4'h9, 0, 1, 0, 4'b0111));
    in_valid = 0;
    step("idle_hold", mk(0, 32'h44, 4'h9, 0, 1, 0, 4'b0111));

    in_valid = 1;
    drive(mv("adds_rst", 5'h04, 4'hE, 1, 0, 32'h2, 32'h3, 0, 4'hA,
             mk(0, 0, 0, 0, 0, 0, 0)));
    step("adds_pre", mk(1, 32'h5, 4'hA, 1, 0, 0, 4'b0000));
    reset = 0;
    step("reset_mid", mk(0, 32'h0, 4'h0, 0, 0, 0, 4'b0000));
    reset = 1; in_valid = 0;
    step("post_reset", mk(0, 32'h0, 4'h0, 0, 0, 0, 4'b0000));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/execute_alu.md
# execute_alu

Registered execute stage sitting directly downstream of the operand-2 shifter. Each cycle it takes the shifter's `shiftedData` together with the Rn operand, PC and decode fields. It evaluates the ARM condition code against the stored NZCV flags and performs the data-processing, address or branch-target arithmetic. It then registers the result, destination control and updated flags for the memory/write-back stage.

## Interface
Parameters: none (datapath fixed at 32 bits, 4 flags).

- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-low reset
- in_valid  in  1  an instruction is presented this cycle
- stall  in  1  hold all state (outputs and flags) this cycle
- flush  in  1  discard the instruction presented this cycle and invalidate the output
- opcode  in  5  0xxxx = data-processing with ARM opcode [3:0]; 10000 = load/store address; 10001 = branch
- cond  in  4  ARM condition field
- set_flags  in  1  S bit; ignored for opcodes 10000/10001
- up_down  in  1  U bit for 10000: 1 = add offset, 0 = subtract
- rnData  in  32  first operand (Rn)
- shiftedData  in  32  operand 2 from the shifter
- pcData  in  32  PC value for branch target (already PC+8)
- rdIn  in  4  destination register
- out_valid  out  1  registered result valid
- result  out  32  ALU result / address / branch target
- rdOut  out  4  registered destination
- writeReg  out  1  write result to rdOut
- memAccess  out  1  result is a load/store address
- branchTaken  out  1  take branch to result
- flags  out  4  current NZCV register {N,Z,C,V}

## Operation
- Accept when reset=1, in_valid=1, stall=0 and flush=0.
- Condition pass uses the flags register value before this instruction's update. The 15 ARM codes 0000–1110 apply (EQ, NE, CS, CC, MI, PL, VS, VC, HI, LS, GE, LT, GT, LE, AL). 1111 never passes.
- Condition fail: out_valid=1, writeReg=memAccess=branchTaken=0, flags unchanged, result = 0.
- Data-processing results, where A=rnData, B=shiftedData:
  - AND: A&B
  - EOR: A^B
  - SUB: A−B
  - RSB: B−A
  - ADD: A+B
  - ADC: A+B+C
  - SBC: A−B−!C
  - RSC: B−A−!C
  - TST: A&B
  - TEQ: A^B
  - CMP: A−B
  - CMN: A+B
  - ORR: A|B
  - MOV: B
  - BIC: A&~B
  - MVN: ~B
- writeReg=1 on pass except for TST/TEQ/CMP/CMN, which always write 0.
- Flag update occurs on pass when set_flags=1 or the opcode is TST/TEQ/CMP/CMN:
  - N = result[31]; Z = (result==0).
  - Arithmetic ops: C = 33-bit carry out. For subtracts C = NOT borrow. V = signed overflow.
  - Logical ops: C and V unchanged.
- 10000: result = up_down ? A+B : A−B; memAccess=1; writeReg=0; flags never change.
- 10001: result = pcData+B; branchTaken=1 on pass; writeReg=0; flags never change.
- All arithmetic is modulo 2^32. Carry and overflow are computed on a 33-bit sum using two's-complement operand inversion.

## Timing
- Latency 1: the instruction accepted at edge k appears on the outputs after edge k. Its flags are visible to an instruction accepted at edge k+1, so back-to-back flag use needs no bubble.
- Cycles with in_valid=0 and no stall/flush: out_valid←0, other outputs hold, flags hold.
- stall=1 (flush=0): every register holds, including out_valid.
- flush=1: out_valid←0, writeReg/memAccess/branchTaken←0, flags hold. flush has priority over stall and in_valid.
- reset=0 at an edge: out_valid, result, rdOut, writeReg, memAccess, branchTaken ← 0 and flags ← 0000. Reset has priority over everything, and an instruction in flight is lost.

## Test plan
- Reset, then ADDS (opcode 00100, S=1, cond AL) with A=0x7FFFFFFF, B=1: result 0x80000000, writeReg=1, flags N=1 Z=0 C=0 V=1.
- CMP with A=5, B=5, then next cycle MOVEQ (cond 0000, B=0xAB) followed by MOVNE (cond 0001): CMP gives flags Z=1 C=1 and writeReg=0. MOVEQ writes 0xAB. MOVNE gives out_valid=1, writeReg=0.
- SUBS with A=0, B=1, then ADC with A=0, B=0: first gives 0xFFFFFFFF, N=1 C=0. ADC gives result 0.
- Load/store with A=0x100, B=0x10: up_down=1 gives 0x110 with memAccess=1; up_down=0 gives 0xF0. Flags unchanged in both cases.
- Branch AL with pcData=0x208, B=0xFFFFFFF8: result 0x200, branchTaken=1. The same branch with cond 1111 gives branchTaken=0.
- ADDS presented with stall=1 for two cycles then flush=1: outputs and flags frozen during the stall. After the flush edge, out_valid=0 and flags are unchanged. Asserting reset mid-stream clears all outputs and sets flags to 0000.
